// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the multiplexed-bus RTC access engine.
package rtc_bus_pkg;

  // Access sequencer states
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ADDR_SETUP = 4'd1,
    S_ADDR_CS    = 4'd2,
    S_ADDR_STB   = 4'd3,
    S_ADDR_HOLD  = 4'd4,
    S_TURN       = 4'd5,
    S_DATA_CS    = 4'd6,
    S_DATA_STB   = 4'd7,
    S_DATA_END   = 4'd8,
    S_RECOVER    = 4'd9
  } state_e;

  // Default phase widths in clock cycles
  localparam int unsigned T_ADDR_DEF    = 6;
  localparam int unsigned T_HOLD_DEF    = 1;
  localparam int unsigned T_TURN_DEF    = 8;
  localparam int unsigned T_DATA_DEF    = 6;
  localparam int unsigned T_RECOVER_DEF = 10;

  // RTC register map
  localparam logic [7:0] RTC_REG_YEAR     = 8'h26;
  localparam logic [7:0] RTC_REG_MONTH    = 8'h25;
  localparam logic [7:0] RTC_REG_DAY      = 8'h24;
  localparam logic [7:0] RTC_REG_HOUR     = 8'h23;
  localparam logic [7:0] RTC_REG_MIN      = 8'h22;
  localparam logic [7:0] RTC_REG_SEC      = 8'h21;
  localparam logic [7:0] RTC_REG_CHR_HOUR = 8'h43;
  localparam logic [7:0] RTC_REG_CHR_MIN  = 8'h42;
  localparam logic [7:0] RTC_REG_CHR_SEC  = 8'h41;
  localparam logic [7:0] RTC_REG_CMD      = 8'hF0;

  // Larger of two widths, used to size the phase counter
  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that measures the dwell of each bus phase.
module rtc_phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done_c
);

  logic [CW-1:0] r_count;

  // Load on phase entry, count down and park at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done_c = (r_count == '0);

endmodule

// File: rtl/rtc_mux_bus_master.sv
// One-access-per-request engine for multiplexed address/data RTC chips.
module rtc_mux_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned T_ADDR    = T_ADDR_DEF,
  parameter int unsigned T_HOLD    = T_HOLD_DEF,
  parameter int unsigned T_TURN    = T_TURN_DEF,
  parameter int unsigned T_DATA    = T_DATA_DEF,
  parameter int unsigned T_RECOVER = T_RECOVER_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rnw,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic [DW-1:0] ad_in,
  output logic [DW-1:0] ad_out,
  output logic          bus_oe,
  output logic          ad_n,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n
);

  localparam int unsigned T_MAX = f_max(f_max(f_max(T_ADDR, T_HOLD), f_max(T_TURN, T_DATA)),
                                        T_RECOVER);
  localparam int unsigned CW    = 32'($clog2(T_MAX)) + 1;

  state_e        r_state;
  state_e        w_next;
  logic          w_accept;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;

  logic          r_rnw;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          r_ad_n, r_cs_n, r_wr_n, r_rd_n, r_bus_oe;
  logic [DW-1:0] r_ad_out;
  logic          r_req_ready, r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

  logic          w_ad_n, w_cs_n, w_wr_n, w_rd_n, w_bus_oe;
  logic [DW-1:0] w_ad_out;

  // Counter preload for a phase: dwell minus one, single-cycle phases load zero
  function automatic logic [CW-1:0] f_dwell(input state_e s);
    case (s)
      S_ADDR_STB:  return CW'(T_ADDR - 1);
      S_ADDR_HOLD: return CW'(T_HOLD - 1);
      S_TURN:      return CW'(T_TURN - 1);
      S_DATA_STB:  return CW'(T_DATA - 1);
      S_RECOVER:   return CW'(T_RECOVER - 1);
      default:     return '0;
    endcase
  endfunction

  rtc_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done_c   (w_done)
  );

  // Next state, phase-counter load and decode of the registered bus outputs
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ad_n     = 1'b1;
    w_cs_n     = 1'b1;
    w_wr_n     = 1'b1;
    w_rd_n     = 1'b1;
    w_bus_oe   = 1'b0;
    w_ad_out   = '1;

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept = 1'b1;
          w_next   = S_ADDR_SETUP;
        end
      end
      S_ADDR_SETUP: if (w_done) w_next = S_ADDR_CS;
      S_ADDR_CS:    if (w_done) w_next = S_ADDR_STB;
      S_ADDR_STB:   if (w_done) w_next = S_ADDR_HOLD;
      S_ADDR_HOLD:  if (w_done) w_next = S_TURN;
      S_TURN:       if (w_done) w_next = S_DATA_CS;
      S_DATA_CS:    if (w_done) w_next = S_DATA_STB;
      S_DATA_STB:   if (w_done) w_next = S_DATA_END;
      S_DATA_END:   if (w_done) w_next = S_RECOVER;
      S_RECOVER:    if (w_done) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase

    w_load     = (w_next != r_state);
    w_load_val = f_dwell(w_next);

    case (w_next)
      S_ADDR_SETUP: begin
        w_ad_n = 1'b0;
      end
      S_ADDR_CS: begin
        w_ad_n = 1'b0;
        w_cs_n = 1'b0;
      end
      S_ADDR_STB: begin
        w_ad_n   = 1'b0;
        w_cs_n   = 1'b0;
        w_wr_n   = 1'b0;
        w_bus_oe = 1'b1;
        w_ad_out = r_addr;
      end
      S_ADDR_HOLD: begin
        w_bus_oe = 1'b1;
        w_ad_out = r_addr;
      end
      S_TURN, S_DATA_END: begin
        w_bus_oe = ~r_rnw;
        w_ad_out = r_rnw ? '1 : r_wdata;
      end
      S_DATA_CS: begin
        w_cs_n   = 1'b0;
        w_bus_oe = ~r_rnw;
        w_ad_out = r_rnw ? '1 : r_wdata;
      end
      S_DATA_STB: begin
        w_cs_n   = 1'b0;
        w_rd_n   = ~r_rnw;
        w_wr_n   = r_rnw;
        w_bus_oe = ~r_rnw;
        w_ad_out = r_rnw ? '1 : r_wdata;
      end
      default: ;
    endcase
  end

  // State, request latch, read capture and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rnw       <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ad_n      <= 1'b1;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_bus_oe    <= 1'b0;
      r_ad_out    <= '1;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_ad_n      <= w_ad_n;
      r_cs_n      <= w_cs_n;
      r_wr_n      <= w_wr_n;
      r_rd_n      <= w_rd_n;
      r_bus_oe    <= w_bus_oe;
      r_ad_out    <= w_ad_out;
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (r_state == S_RECOVER) && (w_next == S_IDLE);
      if (w_accept) begin
        r_rnw   <= req_rnw;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == S_DATA_STB) && w_done && r_rnw) begin
        r_rsp_rdata <= ad_in;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ad_out    = r_ad_out;
  assign bus_oe    = r_bus_oe;
  assign ad_n      = r_ad_n;
  assign cs_n      = r_cs_n;
  assign wr_n      = r_wr_n;
  assign rd_n      = r_rd_n;

endmodule

// File: tb/tb_rtc_mux_bus_master.sv
// Bench for rtc_mux_bus_master: default-timing and short-timing instances side by side.
module tb_rtc_mux_bus_master;
  import rtc_bus_pkg::*;

  localparam int TA = 6;
  localparam int TH = 1;
  localparam int TD = 6;

  int tt_d [2] = '{8, 2};
  int tr_d [2] = '{10, 1};

  logic       clock = 1'b0;
  logic       reset     [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_rnw   [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] ad_in     [2];
  logic [7:0] ad_out    [2];
  logic       bus_oe    [2];
  logic       ad_n      [2];
  logic       cs_n      [2];
  logic       wr_n      [2];
  logic       rd_n      [2];

  logic [7:0] last_rd [2];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rtc_mux_bus_master #(.DW(8)) u_dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_rnw(req_rnw[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .ad_in(ad_in[0]), .ad_out(ad_out[0]),
    .bus_oe(bus_oe[0]), .ad_n(ad_n[0]), .cs_n(cs_n[0]), .wr_n(wr_n[0]), .rd_n(rd_n[0])
  );

  rtc_mux_bus_master #(.DW(8), .T_TURN(2), .T_RECOVER(1)) u_dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_rnw(req_rnw[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .ad_in(ad_in[1]), .ad_out(ad_out[1]),
    .bus_oe(bus_oe[1]), .ad_n(ad_n[1]), .cs_n(cs_n[1]), .wr_n(wr_n[1]), .rd_n(rd_n[1])
  );

  typedef struct packed {
    logic       ad_n;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       oe;
    logic [7:0] ad;
    logic       rsp;
    logic       rdy;
  } obs_t;

  typedef struct {
    int         d;
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] bus;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    o.ad_n = ad_n[d];
    o.cs_n = cs_n[d];
    o.wr_n = wr_n[d];
    o.rd_n = rd_n[d];
    o.oe   = bus_oe[d];
    o.ad   = ad_out[d];
    o.rsp  = rsp_valid[d];
    o.rdy  = req_ready[d];
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '{ad_n: 1'b1, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, oe: 1'b0, ad: 8'hFF, rsp: 1'b0, rdy: 1'b0};
    return o;
  endfunction

  // Expected pins j edges after the accepting edge, from the phase-width timeline
  function automatic obs_t exp_obs(input int j, input int d, input logic rnw,
                                   input logic [7:0] addr, input logic [7:0] wdata);
    obs_t o;
    int s_hold, s_turn, s_dcs, s_dend, n;
    s_hold = 2 + TA;
    s_turn = s_hold + TH;
    s_dcs  = s_turn + tt_d[d];
    s_dend = s_dcs + 1 + TD;
    n      = s_dend + 1 + tr_d[d];
    o = idle_obs();
    if (j == 0) begin
      o.ad_n = 1'b0;
    end else if (j == 1) begin
      o.ad_n = 1'b0; o.cs_n = 1'b0;
    end else if (j < s_hold) begin
      o.ad_n = 1'b0; o.cs_n = 1'b0; o.wr_n = 1'b0; o.oe = 1'b1; o.ad = addr;
    end else if (j < s_turn) begin
      o.oe = 1'b1; o.ad = addr;
    end else if (j <= s_dend) begin
      if (!rnw) begin o.oe = 1'b1; o.ad = wdata; end
      if (j >= s_dcs && j < s_dend) o.cs_n = 1'b0;
      if (j > s_dcs && j < s_dend) begin
        if (rnw) o.rd_n = 1'b0; else o.wr_n = 1'b0;
      end
    end else if (j == n) begin
      o.rsp = 1'b1; o.rdy = 1'b1;
    end
    return o;
  endfunction

  // Issue one access on instance d and check every cycle until its response
  task automatic run_txn(input int d, input logic rnw, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] bus,
                         output int lat, output int nwr, output int nrd);
    int w, n, w_lo, w_hi;
    obs_t o, e;
    logic [7:0] exp_rd;
    exp_rd = rnw ? bus : last_rd[d];
    last_rd[d] = exp_rd;
    n    = 4 + TA + TH + tt_d[d] + TD + tr_d[d];
    w_lo = 3 + TA + TH + tt_d[d];
    w_hi = w_lo + TD - 1;
    w = 0;
    while (req_ready[d] !== 1'b1 && w < 20) begin
      @(posedge clock); #1; w++;
    end
    chk($sformatf("ready_before_req d%0d", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_rnw[d] = rnw; req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clock); #1;
    req_valid[d] = 1'b0;
    req_rnw[d] = 1'($urandom); req_addr[d] = 8'($urandom); req_wdata[d] = 8'($urandom);
    lat = -1; nwr = 0; nrd = 0;
    for (int j = 0; j <= n; j++) begin
      ad_in[d] = (j >= w_lo && j <= w_hi) ? bus : 8'($urandom);
      o = sample(d);
      e = exp_obs(j, d, rnw, addr, wdata);
      chk($sformatf("pins d%0d addr%0h j%0d", d, addr, j), 32'(o), 32'(e));
      if (o.rsp && lat < 0) lat = j;
      if (!o.wr_n) nwr++;
      if (!o.rd_n) nrd++;
      if (j == n) chk($sformatf("rdata d%0d addr%0h", d, addr), 32'(rsp_rdata[d]), 32'(exp_rd));
      if (j < n) begin @(posedge clock); #1; end
    end
  endtask

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, nrd, e, acc1, acc2, rsp1, rsp2, adfall, w;
    bit acc, rdy_leak, seen_rsp;
    logic [7:0] v_addr, v_wdata, v_bus;
    logic v_rnw;
    int d;

    tbl[0] = '{0, 1'b1, RTC_REG_SEC,     8'h00, 8'h37, 8'h37, 35, 6, 6};
    tbl[1] = '{0, 1'b0, RTC_REG_MIN,     8'h59, 8'hC3, 8'h37, 35, 12, 0};
    tbl[2] = '{0, 1'b1, RTC_REG_CMD,     8'h00, 8'hA5, 8'hA5, 35, 6, 6};
    tbl[3] = '{1, 1'b1, RTC_REG_CHR_SEC, 8'h00, 8'h5C, 8'h5C, 20, 6, 6};
    tbl[4] = '{1, 1'b0, RTC_REG_CHR_HOUR,8'h12, 8'h77, 8'h5C, 20, 12, 0};
    tbl[5] = '{0, 1'b1, RTC_REG_HOUR,    8'h00, 8'h00, 8'h00, 35, 6, 6};
    tbl[6] = '{0, 1'b1, RTC_REG_DAY,     8'h00, 8'hFF, 8'hFF, 35, 6, 6};

    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_rnw[i] = 1'b1;
      req_addr[i] = 8'h00; req_wdata[i] = 8'h00; ad_in[i] = 8'hFF; last_rd[i] = 8'h00;
    end

    // Reset state
    repeat (3) begin @(posedge clock); #1; end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_pins d%0d", i), 32'(sample(i)), 32'(idle_obs()));
      chk($sformatf("reset_rdata d%0d", i), 32'(rsp_rdata[i]), 32'd0);
    end
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) chk($sformatf("ready_after_reset d%0d", i), 32'(req_ready[i]), 32'd1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].d, tbl[i].rnw, tbl[i].addr, tbl[i].wdata, tbl[i].bus, lat, nwr, nrd);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d wr_low_cycles", i), 32'(nwr), 32'(tbl[i].exp_wr));
      chk($sformatf("vec%0d rd_low_cycles", i), 32'(nrd), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d rdata", i), 32'(rsp_rdata[tbl[i].d]), 32'(tbl[i].exp_rdata));
    end

    // Randomized accesses on both instances
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      v_rnw = 1'($urandom); v_addr = 8'($urandom); v_wdata = 8'($urandom); v_bus = 8'($urandom);
      run_txn(d, v_rnw, v_addr, v_wdata, v_bus, lat, nwr, nrd);
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(4 + TA + TH + tt_d[d] + TD + tr_d[d]));
      chk($sformatf("rand%0d wr_low_cycles", i), 32'(nwr), 32'(v_rnw ? TA : TA + TD));
      chk($sformatf("rand%0d rd_low_cycles", i), 32'(nrd), 32'(v_rnw ? TD : 0));
    end

    // Back-to-back: valid held across two reads
    @(posedge clock); #1;
    ad_in[0] = 8'h11;
    req_valid[0] = 1'b1; req_rnw[0] = 1'b1; req_addr[0] = RTC_REG_YEAR;
    e = 0; acc1 = -1; acc2 = -1; rsp1 = -1; rsp2 = -1; adfall = -1; rdy_leak = 1'b0;
    while (e < 120 && rsp2 < 0) begin
      acc = req_valid[0] && req_ready[0];
      @(posedge clock); #1; e++;
      if (acc) begin
        if (acc1 < 0) begin acc1 = e; req_addr[0] = RTC_REG_MONTH; end
        else begin acc2 = e; req_valid[0] = 1'b0; end
      end
      if (rsp_valid[0]) begin
        if (rsp1 < 0) rsp1 = e; else rsp2 = e;
      end
      if (acc2 >= 0 && adfall < 0 && ad_n[0] == 1'b0) adfall = e;
      if (acc1 >= 0 && rsp1 < 0 && req_ready[0]) rdy_leak = 1'b1;
    end
    req_valid[0] = 1'b0;
    chk("b2b first_rsp", 32'(rsp1 - acc1), 32'd35);
    chk("b2b second_accept", 32'(acc2 - acc1), 32'd36);
    chk("b2b ad_n_fall", 32'(adfall - acc1), 32'd36);
    chk("b2b second_rsp", 32'(rsp2 - acc1), 32'd71);
    chk("b2b ready_low_between", 32'(rdy_leak), 32'd0);
    chk("b2b rdata", 32'(rsp_rdata[0]), 32'h11);
    last_rd[0] = 8'h11;

    // Reset in the middle of a read's data strobe
    @(posedge clock); #1;
    ad_in[0] = 8'h6B;
    req_valid[0] = 1'b1; req_rnw[0] = 1'b1; req_addr[0] = RTC_REG_SEC;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    w = 0;
    while (rd_n[0] !== 1'b0 && w < 60) begin @(posedge clock); #1; w++; end
    chk("midreset reached_data_stb", 32'(rd_n[0]), 32'd0);
    @(posedge clock); #1;
    reset[0] = 1'b1;
    @(posedge clock); #1;
    reset[0] = 1'b0;
    chk("midreset strobes", 32'({ad_n[0], cs_n[0], wr_n[0], rd_n[0]}), 32'hF);
    chk("midreset bus_oe", 32'(bus_oe[0]), 32'd0);
    chk("midreset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midreset rdata", 32'(rsp_rdata[0]), 32'd0);
    seen_rsp = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (rsp_valid[0]) seen_rsp = 1'b1;
    end
    chk("midreset no_rsp_pulse", 32'(seen_rsp), 32'd0);
    last_rd[0] = 8'h00;
    run_txn(0, 1'b1, RTC_REG_HOUR, 8'h00, 8'h42, lat, nwr, nrd);
    chk("after_reset latency", 32'(lat), 32'd35);
    chk("after_reset rdata", 32'(rsp_rdata[0]), 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
